// File: rtl/rectangle_key_sched_if.sv
// Handshake bundle for the RECTANGLE-80 key schedule; the replay input exists only
// when the round-key buffer is built (RECT_KS_RKBUF_EN).
interface rectangle_key_sched_if;
   logic        start;
   logic [79:0] key;
   logic        busy;
   logic        rk_valid;
   logic        rk_ready;
   logic [63:0] rk;
   logic [4:0]  rk_idx;
   logic        done;
   logic        dbg_run;
`ifdef RECT_KS_RKBUF_EN
   logic        replay;

   modport master (output start, key, rk_ready, replay,
                   input busy, rk_valid, rk, rk_idx, done, dbg_run);
   modport slave  (input start, key, rk_ready, replay,
                   output busy, rk_valid, rk, rk_idx, done, dbg_run);
`else
   modport master (output start, key, rk_ready,
                   input busy, rk_valid, rk, rk_idx, done, dbg_run);
   modport slave  (input start, key, rk_ready,
                   output busy, rk_valid, rk, rk_idx, done, dbg_run);
`endif
endinterface

// File: rtl/rectangle_key_sched.sv
// RECTANGLE-80 key schedule: emits rk0..rkROUNDS over a valid/ready stream.
// Optional reverse-replay buffer enabled by macro RECT_KS_RKBUF_EN.

module rectangle_sbox (
   input  logic [3:0] x,
   output logic [3:0] y
);
   always_comb begin
      y = 4'h0;
      case (x)
         4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
         4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
         4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
         4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
   end
endmodule

module rectangle_key_sched #(
   parameter int ROUNDS = 25
) (
   input logic clk,
   input logic rst,
   rectangle_key_sched_if.slave bus
);
   // Handshake: a round key transfers on a rising edge where rk_valid and rk_ready
   // are both high; while rk_ready is low rk and rk_idx hold their values.
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

   state_t      state;
   logic [79:0] key_reg;
   logic [4:0]  rc;
   logic [4:0]  rk_idx;
   logic        rk_valid;
   logic        busy;
   logic        done;
   logic [3:0]  s_out [4];
   logic [15:0] r0, r1, r2, r3, r4;
   logic [79:0] key_next;
   logic        accept;
   logic        last_hs;

   for (genvar j = 0; j < 4; j++) begin : g_sbox
      rectangle_sbox u_sbox (
         .x({key_reg[48+j], key_reg[32+j], key_reg[16+j], key_reg[j]}),
         .y(s_out[j])
      );
   end

   always_comb begin
      r0 = key_reg[15:0];
      r1 = key_reg[31:16];
      r2 = key_reg[47:32];
      r3 = key_reg[63:48];
      r4 = key_reg[79:64];
      for (int j = 0; j < 4; j++) begin
         r0[j] = s_out[j][0];
         r1[j] = s_out[j][1];
         r2[j] = s_out[j][2];
         r3[j] = s_out[j][3];
      end
      // Row mix (rotations by 8 and 12) with the round constant folded into row0.
      key_next = {r0,
                  {r3[3:0], r3[15:4]} ^ r4,
                  r3,
                  r2,
                  ({r0[7:0], r0[15:8]} ^ r1) ^ {11'h000, rc}};
   end

`ifdef RECT_KS_RKBUF_EN
   logic        replay_mode;
   logic        buf_valid;
   logic [63:0] rk_buf [0:ROUNDS];

   assign accept  = bus.start && (!bus.replay || buf_valid);
   assign last_hs = replay_mode ? (rk_idx == 5'd0) : (rk_idx == LAST_IDX);
   assign bus.rk  = replay_mode ? rk_buf[rk_idx] : key_reg[63:0];

   always_ff @(posedge clk) begin
      if (state == RUN && rk_valid && bus.rk_ready && !replay_mode)
         rk_buf[rk_idx] <= key_reg[63:0];
   end
`else
   assign accept  = bus.start;
   assign last_hs = (rk_idx == LAST_IDX);
   assign bus.rk  = key_reg[63:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         key_reg  <= '0;
         rc       <= 5'h01;
         rk_idx   <= '0;
         rk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef RECT_KS_RKBUF_EN
         replay_mode <= 1'b0;
         buf_valid   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= RUN;
                  rk_valid <= 1'b1;
                  busy     <= 1'b1;
                  rc       <= 5'h01;
`ifdef RECT_KS_RKBUF_EN
                  replay_mode <= bus.replay;
                  if (bus.replay) begin
                     rk_idx <= LAST_IDX;
                  end else begin
                     key_reg <= bus.key;
                     rk_idx  <= '0;
                  end
`else
                  key_reg <= bus.key;
                  rk_idx  <= '0;
`endif
               end
            end
            RUN: begin
               if (bus.rk_ready) begin
                  if (last_hs) begin
                     state    <= IDLE;
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
`ifdef RECT_KS_RKBUF_EN
                     buf_valid <= 1'b1;
`endif
                  end else begin
`ifdef RECT_KS_RKBUF_EN
                     if (replay_mode) begin
                        rk_idx <= rk_idx - 5'd1;
                     end else begin
                        key_reg <= key_next;
                        rc      <= {rc[3:0], rc[4] ^ rc[2]};
                        rk_idx  <= rk_idx + 5'd1;
                     end
`else
                     key_reg <= key_next;
                     rc      <= {rc[3:0], rc[4] ^ rc[2]};
                     rk_idx  <= rk_idx + 5'd1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy;
   assign bus.rk_valid = rk_valid;
   assign bus.rk_idx   = rk_idx;
   assign bus.done     = done;
   assign bus.dbg_run  = (state == RUN);
endmodule

// File: doc/rectangle_key_sched.md
RECTANGLE_KEY_SCHED -- requirements
Module: rectangle_key_sched

Interface
REQ-001 Parameter ROUNDS, default 25, number of cipher rounds; round keys rk0..rkROUNDS are emitted (26 by default).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a schedule; sampled only in IDLE.
REQ-005 key  in  80  master key; rows row_i = key[16i+15:16i], i=0..4; sampled on accepted start.
REQ-006 busy  out  1  high in every state other than IDLE.
REQ-007 rk_valid  out  1  round key on rk is valid.
REQ-008 rk_ready  in  1  consumer accepts rk when high together with rk_valid.
REQ-009 rk  out  64  current round key = key_reg[63:0] (rows 3..0).
REQ-010 rk_idx  out  5  index of the round key on rk, 0..ROUNDS.
REQ-011 done  out  1  one-cycle pulse after the last round key handshake.

Function
REQ-012 FSM states IDLE, RUN; IDLE->RUN on start; RUN->IDLE on handshake with rk_idx==ROUNDS.
REQ-013 Accepted start: key_reg<=key, rc<=5'h01, rk_idx<=0; rk_valid rises the following cycle (latency 1).
REQ-014 start while busy is ignored; key input is not re-sampled.
REQ-015 In RUN rk_valid is high; rk and rk_idx hold stable while rk_ready is low (no key update, no rc advance).
REQ-016 On handshake with rk_idx<ROUNDS: key_reg<=update(key_reg,rc), rc<=lfsr(rc), rk_idx<=rk_idx+1; next key valid the next cycle (one key per cycle under continuous ready).
REQ-017 update step 1: columns j=0..3 substituted via the existing sbox module, input {row3[j],row2[j],row1[j],row0[j]} (MSB row3), outputs written back in the same bit order; columns 4..15 unchanged.
REQ-018 update step 2: row0'=(row0<<<8)^row1, row1'=row2, row2'=row3, row3'=(row3<<<12)^row4, row4'=row0 (rows after step 1).
REQ-019 update step 3: row0'[4:0] ^= rc.
REQ-020 lfsr: {rc4..rc0} -> {rc3,rc2,rc1,rc0,rc4^rc2}.
REQ-021 Handshake with rk_idx==ROUNDS: rk_valid low next cycle, done pulses exactly one cycle, state IDLE.
REQ-022 start asserted in the same cycle as the final handshake is ignored; a new schedule needs start in IDLE.

Reset
REQ-023 rst asserted (any state, incl. mid-schedule): state IDLE, key_reg=0, rc=5'h01, rk_idx=0, rk_valid=0, busy=0, done=0, rk=0 immediately, without waiting for clk.
REQ-024 Release of rst mid-handshake leaves no partial schedule; outputs remain reset values until a new start.

Configuration
REQ-025 Macro RECT_KS_RKBUF_EN: when defined, a 26x64 round-key buffer stores each emitted rk at rk_idx, and input port replay (1 bit) is added.
REQ-026 With RECT_KS_RKBUF_EN: buf_valid set on done, cleared by rst; start with replay=1 and buf_valid=1 streams buffered keys in reverse order, rk_idx ROUNDS..0, same handshake, no key_reg update, done after index 0; replay=1 with buf_valid=0 ignores start.
REQ-027 Without RECT_KS_RKBUF_EN: no buffer, no replay port; behaviour exactly REQ-012..REQ-022.

Verification
REQ-028 key=80'h0, start, rk_ready=1 -> rk0=64'h0, rk1=64'h0000_0000_000F_000E, 26 keys on consecutive cycles, done one cycle after rk_idx=25 handshake.
REQ-029 Random key, rk_ready toggled randomly -> rk/rk_idx stable during stalls; sequence matches a software model (REQ-017..020).
REQ-030 rc sequence check: rc used for rk1..rk6 = 01,02,04,09,12,05.
REQ-031 rst asserted at rk_idx=10 -> all outputs zero asynchronously; subsequent start with same key reproduces rk0 onward.
REQ-032 start pulsed during RUN with a different key -> ignored; sequence continues from original key.
REQ-033 RECT_KS_RKBUF_EN: after full schedule, start with replay=1 -> rk_idx 25..0 with keys equal to forward run in reverse; replay before any schedule -> busy stays 0.
